// File: rtl/aes_cipher_top_core.sv
`default_nettype none
// ============================================================================
// aes_cipher_top_core : iterative AES-128 encryptor, one round per clock,
// round keys expanded on the fly. Option macro: AES_LD_RESTART_EN.
// Revision: 1.0
// ============================================================================
module aes_cipher_top_core (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic         done,
   output logic [127:0] text_out
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [0:255][7:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t       r_state, w_state_nxt;
   logic [3:0]   r_round, w_round_nxt;
   logic [127:0] r_key, w_key_nxt;
   logic [127:0] r_data, w_data_nxt;
   logic [127:0] r_text_out, w_text_out_nxt;
   logic         r_done, w_done_nxt;

   logic [127:0] w_round_key;
   logic [127:0] w_sub_shift;
   logic [127:0] w_mix;
   logic [127:0] w_round_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] v;
      case (rnd)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Byte i of the state lives at [127-8i -: 8]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = c_sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return o;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {c_sbox[w3[23:16]], c_sbox[w3[15:8]], c_sbox[w3[7:0]], c_sbox[w3[31:24]]}
           ^ {rc, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   assign w_round_key = next_key(r_key, rcon(r_round));
   assign w_sub_shift = sub_shift(r_data);
   assign w_mix       = mix_columns(w_sub_shift);
   // The final round skips MixColumns.
   assign w_round_out = ((r_round == 4'd10) ? w_sub_shift : w_mix) ^ w_round_key;

   always_comb begin
      w_state_nxt    = r_state;
      w_round_nxt    = r_round;
      w_key_nxt      = r_key;
      w_data_nxt     = r_data;
      w_text_out_nxt = r_text_out;
      w_done_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            if (ld) begin
               w_key_nxt   = key;
               w_data_nxt  = text_in ^ key;
               w_round_nxt = 4'd1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            w_key_nxt  = w_round_key;
            w_data_nxt = w_round_out;
            if (r_round == 4'd10) begin
               w_text_out_nxt = w_round_out;
               w_done_nxt     = 1'b1;
               w_round_nxt    = 4'd0;
               w_state_nxt    = IDLE;
            end else begin
               w_round_nxt = r_round + 4'd1;
            end
`ifdef AES_LD_RESTART_EN
            // A new load aborts the running operation, including its final round.
            if (ld) begin
               w_key_nxt      = key;
               w_data_nxt     = text_in ^ key;
               w_round_nxt    = 4'd1;
               w_state_nxt    = BUSY;
               w_text_out_nxt = r_text_out;
               w_done_nxt     = 1'b0;
            end
`endif
         end
         default: begin
            w_state_nxt = IDLE;
            w_round_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_round    <= 4'd0;
         r_key      <= '0;
         r_data     <= '0;
         r_text_out <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_round    <= w_round_nxt;
         r_key      <= w_key_nxt;
         r_data     <= w_data_nxt;
         r_text_out <= w_text_out_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign done     = r_done;
   assign text_out = r_text_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_top_core.sv
`default_nettype none
// Testbench for aes_cipher_top_core: random and known-answer stimulus, scoreboard
// fed by a byte-level AES-128 reference model with a computed S-box.
module tb_aes_cipher_top_core;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ld = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] text_in = '0;
   logic         done;
   logic [127:0] text_out;

   aes_cipher_top_core dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .key      (key),
      .text_in  (text_in),
      .done     (done),
      .text_out (text_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           done_at;
      logic [127:0] data;
   } exp_t;

   exp_t         exp_q[$];
   int           cyc = 0;
   int           busy_end = 0;
   int           n_chk = 0;
   int           n_err = 0;
   logic         prev_rst = 1'b1;
   logic [127:0] last_out = '0;
   logic [7:0]   sbx [256];

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_rst <= rst;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [7:0]   col [4];
      logic [7:0]   rc;
      logic [31:0]  t;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) st[4*c+r] = st[4*c+r] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) st[i] = sbx[st[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+r)%4)];
         st = tmp;
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) col[r] = st[4*c+r];
               for (int r = 0; r < 4; r++)
                  st[4*c+r] = gmul(col[r], 8'h02) ^ gmul(col[(r+1)%4], 8'h03)
                              ^ col[(r+2)%4] ^ col[(r+3)%4];
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               st[4*c+r] = st[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- stimulus with transaction tracking ----------------
   // Called just after a rising edge; the inputs set here are sampled at edge cyc+1.
   task automatic drive(input logic l, input logic r, input logic [127:0] k,
                        input logic [127:0] t, input logic fixed, input logic [127:0] fixed_val);
      int   n;
      exp_t e;
      n       = cyc + 1;
      ld      = l;
      rst     = r;
      key     = k;
      text_in = t;
      e.done_at = n + 10;
      e.data    = fixed ? fixed_val : aes_ref(k, t);
      if (r) begin
         while (exp_q.size() > 0 && exp_q[$].done_at >= n) void'(exp_q.pop_back());
         busy_end = 0;
      end else if (l) begin
         if (n > busy_end) begin
            exp_q.push_back(e);
            busy_end = n + 10;
         end else begin
`ifdef AES_LD_RESTART_EN
            void'(exp_q.pop_back());
            exp_q.push_back(e);
            busy_end = n + 10;
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, rnd128(), rnd128(), 1'b0, '0);
   endtask

   task automatic start(input logic [127:0] k, input logic [127:0] t);
      drive(1'b1, 1'b0, k, t, 1'b0, '0);
   endtask

   task automatic start_kat(input logic [127:0] k, input logic [127:0] t, input logic [127:0] c);
      drive(1'b1, 1'b0, k, t, 1'b1, c);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      if (prev_rst) begin
         n_chk++;
         if (done !== 1'b0 || text_out !== 128'h0) begin
            n_err++;
            $display("FAIL reset_state: done=%b text_out=%h, required done=0 text_out=0", done, text_out);
         end
      end else if (done === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: cycle %0d text_out=%h, no operation pending", cyc, text_out);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.done_at) begin
               n_err++;
               $display("FAIL done_latency: done at cycle %0d, required cycle %0d", cyc, e.done_at);
            end
            n_chk++;
            if (text_out !== e.data) begin
               n_err++;
               $display("FAIL ciphertext: text_out=%h, required %h", text_out, e.data);
            end
         end
      end else begin
         if (exp_q.size() > 0 && exp_q[0].done_at < cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL missing_done: cycle %0d, required done at cycle %0d", cyc, exp_q[0].done_at);
            void'(exp_q.pop_front());
         end
         n_chk++;
         if (text_out !== last_out) begin
            n_err++;
            $display("FAIL text_out_hold: text_out=%h changed without done, required %h", text_out, last_out);
         end
      end
      last_out = text_out;
   end

   // ---------------- test sequence ----------------
   initial begin
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      drive(1'b0, 1'b1, '0, '0, 1'b0, '0);
      idle(2);

      start_kat(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      idle(12);
      start_kat(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32);
      idle(12);
      start_kat(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      idle(15);

      // Abort by reset at cycle 5 of an operation, then a fresh operation.
      start(rnd128(), rnd128());
      idle(4);
      drive(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, '0);
      idle(3);
      start(128'hcafebabedeadbeefdeadbeef00000000, 128'h5c27ede269c63557c4d676193a9ff18f);
      idle(12);

      // Second load at cycle 4 of an operation.
      start(rnd128(), rnd128());
      idle(3);
      start(rnd128(), rnd128());
      idle(16);

      // Load held high for 25 cycles with changing operands.
      for (int i = 0; i < 25; i++) start(rnd128(), rnd128());
      idle(14);

      // Randomized loads and occasional resets.
      for (int i = 0; i < 150; i++)
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0,
               rnd128(), rnd128(), 1'b0, '0);
      idle(15);

      n_chk++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_cipher_top_core.md
AES_CIPHER_TOP_CORE -- requirements
Module: aes_cipher_top

Interface
REQ-001 Parameters: none; the block SHALL be fixed AES-128 encryption only.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ld  input  1  load/start strobe, sampled on rising clk.
REQ-005 done  output  1  one-cycle pulse: text_out valid and newly updated.
REQ-006 key  input  128  cipher key, sampled only on an accepted ld.
REQ-007 text_in  input  128  plaintext, sampled only on an accepted ld.
REQ-008 text_out  output  128  ciphertext, registered.

Function
REQ-009 The block SHALL implement FIPS-197 AES-128 encryption; the byte order is text_in[127:120] = state byte 0, with column-major state, identical for key and text_out.
REQ-010 Structure: iterative, one round per clock; round keys are expanded on the fly from the previous round key; the S-box uses the combinational FIPS-197 table.
REQ-011 Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-012 FSM states: IDLE, BUSY (round counter 1..10).
  - IDLE with ld=1 at edge N: capture key; state <= text_in XOR key; go to BUSY with round=1.
  - BUSY: rounds 1..9 at edges N+1..N+9 perform SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10 at edge N+10 omits MixColumns.
REQ-013 Latency: at edge N+10, text_out SHALL be loaded with the ciphertext, done SHALL be set to 1, and the FSM SHALL return to IDLE.
REQ-014 done SHALL be high for exactly one cycle and clear at edge N+11 unless a new completion occurs.
REQ-015 text_out SHALL hold its value until the next completion; it SHALL NOT change during BUSY.
REQ-016 ld held high SHALL start back-to-back operations; a new ld accepted in the IDLE cycle right after done starts a new op.
REQ-017 key and text_in SHALL be don't-care except on the accepting edge.
REQ-018 ld while BUSY: the behaviour SHALL be as specified in Configuration.
REQ-019 X on ld when not in reset SHALL NOT be tolerated; ld SHALL be treated as 0 when rst=1.

Reset
REQ-020 rst=1 at a rising edge SHALL force: FSM=IDLE, round=0, done=0, text_out=128'h0, and internal state and round key cleared to 0.
REQ-021 Reset mid-operation SHALL abort the op; no done pulse SHALL occur for it.
REQ-022 Reset SHALL take priority over ld on the same edge.

Configuration
REQ-023 Macro AES_LD_RESTART_EN. Defined: ld=1 while BUSY SHALL abort the current op and restart with the new key and text_in (latency counted from that edge). Undefined: ld while BUSY SHALL be ignored and the current op SHALL complete normally.

Verification
REQ-024 Reset, then key=000102030405060708090a0b0c0d0e0f, text_in=00112233445566778899aabbccddeeff, one-cycle ld -> done exactly 10 cycles after the ld edge, text_out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-025 key=2b7e151628aed2a6abf7158809cf4f3c, text_in=3243f6a8885a308d313198a2e0370734 -> text_out=3925841d02dc09fbdc118597196a0b32; done is high for exactly 1 cycle.
REQ-026 key=0, text_in=0 -> text_out=66e94bd4ef8a2c3b884cfa59ca342b2e; text_out is stable until the next done.
REQ-027 Assert rst at cycle 5 of an op -> no done; text_out=0. A subsequent ld (key=cafebabedeadbeefdeadbeef00000000, text_in=5c27ede269c63557c4d676193a9ff18f) -> text_out matches the software AES-128 model.
REQ-028 Second ld at cycle 4 of an op: with AES_LD_RESTART_EN -> one done, 10 cycles after the second ld, carrying the second result. Without it -> done at the original time with the first result, and the second ld is lost.
REQ-029 ld held high for 25 cycles -> done pulses at consecutive 11-cycle intervals (10 BUSY cycles plus 1 IDLE); each result is correct.
